// File: rtl/up_ctrl_pkg.sv
// Shared types and encodings for the UP multicycle controller.
package up_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_RD_A    = 4'd3,
    S_RD_B    = 4'd4,
    S_WR      = 4'd5,
    S_FLAG    = 4'd6,
    S_BR      = 4'd7,
    S_IO_RD   = 4'd8,
    S_IO_WR   = 4'd9,
    S_SP_INC  = 4'd10,
    S_POP_RD  = 4'd11,
    S_PUSH_WR = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  localparam logic [1:0] CLS_MOV = 2'b00;
  localparam logic [1:0] CLS_ADD = 2'b01;
  localparam logic [1:0] CLS_CMP = 2'b10;
  localparam logic [1:0] CLS_GRP = 2'b11;

  localparam logic [1:0] SUB_BEQ  = 2'b00;
  localparam logic [1:0] SUB_IN   = 2'b01;
  localparam logic [1:0] SUB_OUT  = 2'b10;
  localparam logic [1:0] SUB_MISC = 2'b11;

  localparam logic [1:0] MISC_PUSH = 2'b00;
  localparam logic [1:0] MISC_POP  = 2'b01;
  localparam logic [1:0] MISC_HALT = 2'b10;
  localparam logic [1:0] MISC_NOP  = 2'b11;

  localparam logic [5:0] OP_PUSH = {CLS_GRP, SUB_MISC, MISC_PUSH};

  localparam logic [1:0] MX_PC  = 2'b00;
  localparam logic [1:0] MX_SP  = 2'b01;
  localparam logic [1:0] MX_SRC = 2'b10;
  localparam logic [1:0] MX_DST = 2'b11;

  localparam logic [1:0] ALU_PASS_A = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  // sp_w = {direction, enable}
  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_DEC  = 2'b01;
  localparam logic [1:0] SP_INC  = 2'b11;

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath/peripheral signal bundle.
interface control_unit_if;
  logic [5:0] cop;
  logic       fz;
  logic       io_ack;
  logic       mx1, mx0;
  logic       alu_op1, alu_op0;
  logic       le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio;
  logic [1:0] sp_w;
  logic       io_rd, io_wr;
  logic       halted;
  logic       io_err;

  modport master (
    input  cop, fz, io_ack,
    output mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w,
           mx_memio, sp_w, io_rd, io_wr, halted, io_err
  );

  modport slave (
    output cop, fz, io_ack,
    input  mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w,
           mx_memio, sp_w, io_rd, io_wr, halted, io_err
  );
endinterface

// File: rtl/io_watchdog.sv
// I/O wait counter for the controller; only instantiated when UC_IO_TIMEOUT_EN is defined.
module io_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic timeout,
  output logic err
);
  // Count is 0 in the first I/O cycle, so the LIMIT-th waiting cycle is the abort cycle.
  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_reg;
  logic        err_reg;

  assign timeout = active && (count_reg == LAST);
  assign err     = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= active ? count_reg + 16'd1 : 16'd0;
      err_reg   <= timeout && !ack;
    end
  end
endmodule

// File: rtl/control_unit.sv
// Multicycle fetch/decode/execute controller for the UP datapath with I/O handshake.
// Optional I/O timeout abort is enabled by defining UC_IO_TIMEOUT_EN.
module control_unit
  import up_ctrl_pkg::*;
#(
  parameter int IO_TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset,
  control_unit_if.master bus
);

  if (IO_TIMEOUT < 1 || IO_TIMEOUT > 65535) begin : g_bad_io_timeout
    $error("IO_TIMEOUT must be in 1..65535");
  end

  state_t     state_reg, state_next;
  logic [1:0] mx, alu, sp_w;
  logic       le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio;
  logic       io_rd, io_wr, halted;
  logic       io_timeout;
  logic [1:0] cls, sub, misc;

  assign cls  = bus.cop[5:4];
  assign sub  = bus.cop[3:2];
  assign misc = bus.cop[1:0];

`ifdef UC_IO_TIMEOUT_EN
  logic io_active;
  assign io_active = (state_reg == S_IO_RD) || (state_reg == S_IO_WR);

  io_watchdog #(.LIMIT(IO_TIMEOUT)) u_io_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (io_active),
    .ack     (bus.io_ack),
    .timeout (io_timeout),
    .err     (bus.io_err)
  );
`else
  assign io_timeout = 1'b0;
  assign bus.io_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_RESET;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mx         = MX_PC;
    alu        = ALU_PASS_A;
    sp_w       = SP_HOLD;
    le         = 1'b0;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    a_w        = 1'b0;
    b_w        = 1'b0;
    fz_w       = 1'b0;
    mx_memio   = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      S_RESET: state_next = S_FETCH;

      S_FETCH: begin
        mx         = MX_PC;
        ir_w       = 1'b1;
        pc_w       = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        if (cls != CLS_GRP) begin
          state_next = S_RD_A;
        end else begin
          case (sub)
            SUB_BEQ: state_next = S_BR;
            SUB_IN:  state_next = S_IO_RD;
            SUB_OUT: state_next = S_IO_WR;
            default: begin
              case (misc)
                MISC_PUSH: state_next = S_RD_A;
                MISC_POP:  state_next = S_SP_INC;
                MISC_HALT: state_next = S_HALT;
                default:   state_next = S_FETCH;
              endcase
            end
          endcase
        end
      end

      S_RD_A: begin
        a_w = 1'b1;
        mx  = (bus.cop == OP_PUSH) ? MX_DST : MX_SRC;
        if (cls == CLS_MOV)                       state_next = S_WR;
        else if (cls == CLS_ADD || cls == CLS_CMP) state_next = S_RD_B;
        else if (bus.cop == OP_PUSH)               state_next = S_PUSH_WR;
        else                                       state_next = S_FETCH;
      end

      S_RD_B: begin
        mx         = MX_DST;
        b_w        = 1'b1;
        state_next = (cls == CLS_ADD) ? S_WR : S_FLAG;
      end

      // Shared by MOV, ADD and POP; only ADD updates the flag.
      S_WR: begin
        mx = MX_DST;
        le = 1'b1;
        if (cls == CLS_ADD) begin
          alu  = ALU_ADD;
          fz_w = 1'b1;
        end
        state_next = S_FETCH;
      end

      S_FLAG: begin
        alu        = ALU_SUB;
        fz_w       = 1'b1;
        state_next = S_FETCH;
      end

      S_BR: begin
        if (bus.fz) begin
          mx         = MX_DST;
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end

      S_IO_RD: begin
        mx       = MX_DST;
        mx_memio = 1'b1;
        io_rd    = 1'b1;
        le       = bus.io_ack;
        if (bus.io_ack || io_timeout) state_next = S_FETCH;
      end

      S_IO_WR: begin
        mx    = MX_DST;
        io_wr = 1'b1;
        if (bus.io_ack || io_timeout) state_next = S_FETCH;
      end

      S_PUSH_WR: begin
        mx         = MX_SP;
        alu        = ALU_PASS_A;
        le         = 1'b1;
        sp_w       = SP_DEC;
        state_next = S_FETCH;
      end

      S_SP_INC: begin
        sp_w       = SP_INC;
        state_next = S_POP_RD;
      end

      S_POP_RD: begin
        mx         = MX_SP;
        a_w        = 1'b1;
        state_next = S_WR;
      end

      S_HALT: halted = 1'b1;

      default: state_next = S_RESET;
    endcase
  end

  assign bus.mx1      = mx[1];
  assign bus.mx0      = mx[0];
  assign bus.alu_op1  = alu[1];
  assign bus.alu_op0  = alu[0];
  assign bus.le       = le;
  assign bus.pc_w     = pc_w;
  assign bus.ir_w     = ir_w;
  assign bus.a_w      = a_w;
  assign bus.b_w      = b_w;
  assign bus.fz_w     = fz_w;
  assign bus.mx_memio = mx_memio;
  assign bus.sp_w     = sp_w;
  assign bus.io_rd    = io_rd;
  assign bus.io_wr    = io_wr;
  assign bus.halted   = halted;

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction-stream bench for control_unit against a per-instruction cycle model.
module tb_control_unit;

`ifdef UC_IO_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif

  // Expected-vector layout: {mx[1:0], alu[1:0], le,pc_w,ir_w,a_w,b_w,fz_w,mx_memio, sp_w[1:0], io_rd,io_wr,halted,io_err}
  localparam logic [1:0] M_PC = 2'b00, M_SP = 2'b01, M_SRC = 2'b10, M_DST = 2'b11;
  localparam logic [1:0] A_PA = 2'b00, A_ADD = 2'b01, A_SUB = 2'b10;
  localparam logic [6:0] T_LE = 7'b1000000, T_PC = 7'b0100000, T_IR = 7'b0010000,
                         T_A  = 7'b0001000, T_B  = 7'b0000100, T_FZ = 7'b0000010,
                         T_MIO = 7'b0000001;
  localparam logic [3:0] X_RD = 4'b1000, X_WR = 4'b0100, X_HALT = 4'b0010, X_ERR = 4'b0001;
  localparam logic [16:0] ALL = 17'h1ffff;
  localparam logic [16:0] NO_MIO = 17'h1ffbf;

  localparam int K_MOV = 0, K_ADD = 1, K_CMP = 2, K_BEQ = 3, K_IN = 4,
                 K_OUT = 5, K_PUSH = 6, K_POP = 7, K_HALT = 8, K_NOP = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   skip_fetch = 1'b0;
  bit   err_pending = 1'b0;

  control_unit_if bus();

  control_unit #(.IO_TIMEOUT(TMO > 0 ? TMO : 255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {bus.mx1, bus.mx0, bus.alu_op1, bus.alu_op0, bus.le, bus.pc_w, bus.ir_w,
                bus.a_w, bus.b_w, bus.fz_w, bus.mx_memio, bus.sp_w,
                bus.io_rd, bus.io_wr, bus.halted, bus.io_err};

  function automatic logic [16:0] ov(input logic [1:0] mx, input logic [1:0] alu,
                                     input logic [6:0] st, input logic [1:0] sp,
                                     input logic [3:0] x);
    return {mx, alu, st, sp, x};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are checked at the falling edge.
  task automatic cyc(input string tag, input logic [16:0] exp, input logic ack,
                     input logic f, input logic [16:0] care);
    bus.io_ack = ack;
    bus.fz     = f;
    @(negedge clk);
    check_eq(tag, obs & care, exp & care);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    cyc(tag, '0, rb(), rb(), ALL);
    cyc("rst_hold", '0, rb(), rb(), ALL);
    reset = 1'b1;
    cyc("rst_idle", '0, rb(), rb(), ALL);
    skip_fetch  = 1'b0;
    err_pending = 1'b0;
  endtask

  function automatic logic [5:0] make_cop(input int kind);
    logic [3:0] lo4;
    logic [1:0] lo2;
    lo4 = 4'($urandom);
    lo2 = 2'($urandom);
    case (kind)
      K_MOV:   return {2'b00, lo4};
      K_ADD:   return {2'b01, lo4};
      K_CMP:   return {2'b10, lo4};
      K_BEQ:   return {4'b1100, lo2};
      K_IN:    return {4'b1101, lo2};
      K_OUT:   return {4'b1110, lo2};
      K_PUSH:  return 6'b111100;
      K_POP:   return 6'b111101;
      K_HALT:  return 6'b111110;
      default: return 6'b111111;
    endcase
  endfunction

  task automatic fetch_decode(input logic [5:0] c);
    if (!skip_fetch) begin
      cyc("fetch", ov(M_PC, A_PA, T_PC | T_IR, 2'b00, err_pending ? X_ERR : 4'b0), rb(), rb(), ALL);
      err_pending = 1'b0;
    end
    skip_fetch = 1'b0;
    bus.cop = c;
    cyc("decode", '0, rb(), rb(), ALL);
  endtask

  task automatic run_instr(input int kind, input logic br_fz, input int io_wait);
    logic [5:0]  c;
    logic [16:0] base;
    logic [16:0] care;
    bit          is_in;
    bit          abort;
    int          waits;
    c = make_cop(kind);
    $display("instr kind=%0d cop=%06b fz=%0b io_wait=%0d", kind, c, br_fz, io_wait);
    fetch_decode(c);
    case (kind)
      K_MOV: begin
        cyc("mov_rd_a", ov(M_SRC, A_PA, T_A, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("mov_wr",   ov(M_DST, A_PA, T_LE, 2'b00, 4'b0), rb(), rb(), ALL);
      end
      K_ADD: begin
        cyc("add_rd_a", ov(M_SRC, A_PA, T_A, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("add_rd_b", ov(M_DST, A_PA, T_B, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("add_wr",   ov(M_DST, A_ADD, T_LE | T_FZ, 2'b00, 4'b0), rb(), rb(), ALL);
      end
      K_CMP: begin
        cyc("cmp_rd_a", ov(M_SRC, A_PA, T_A, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("cmp_rd_b", ov(M_DST, A_PA, T_B, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("cmp_flag", ov(M_PC, A_SUB, T_FZ, 2'b00, 4'b0), rb(), rb(), ALL);
      end
      K_BEQ: begin
        if (br_fz) begin
          cyc("br_taken", ov(M_DST, A_PA, T_IR | T_PC, 2'b00, 4'b0), rb(), 1'b1, ALL);
          skip_fetch = 1'b1;
        end else begin
          cyc("br_not_taken", '0, rb(), 1'b0, ALL);
        end
      end
      K_IN, K_OUT: begin
        is_in = (kind == K_IN);
        abort = (TMO > 0) && (io_wait >= TMO);
        waits = abort ? TMO : io_wait;
        base  = is_in ? ov(M_DST, A_PA, T_MIO, 2'b00, X_RD) : ov(M_DST, A_PA, 7'b0, 2'b00, X_WR);
        care  = is_in ? NO_MIO : ALL;
        for (int i = 0; i < waits; i++)
          cyc(is_in ? "in_wait" : "out_wait", base, 1'b0, rb(), care);
        if (abort) err_pending = 1'b1;
        else cyc(is_in ? "in_ack" : "out_ack", base | (is_in ? {4'b0, T_LE, 6'b0} : 17'b0),
                 1'b1, rb(), ALL);
      end
      K_PUSH: begin
        cyc("push_rd_a", ov(M_DST, A_PA, T_A, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("push_wr",   ov(M_SP, A_PA, T_LE, 2'b01, 4'b0), rb(), rb(), ALL);
      end
      K_POP: begin
        cyc("pop_sp_inc", ov(M_PC, A_PA, 7'b0, 2'b11, 4'b0), rb(), rb(), ALL);
        cyc("pop_rd",     ov(M_SP, A_PA, T_A, 2'b00, 4'b0), rb(), rb(), ALL);
        cyc("pop_wr",     ov(M_DST, A_PA, T_LE, 2'b00, 4'b0), rb(), rb(), ALL);
      end
      K_HALT: begin
        for (int i = 0; i < 3; i++)
          cyc("halt", ov(M_PC, A_PA, 7'b0, 2'b00, X_HALT), rb(), rb(), ALL);
        do_reset("rst_after_halt");
      end
      default: ;
    endcase
  endtask

  initial begin
    int kind;
    int r;
    bus.cop    = '0;
    bus.fz     = 1'b0;
    bus.io_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", '0, 1'b1, 1'b1, ALL);
    reset = 1'b1;
    cyc("rst_idle", '0, rb(), rb(), ALL);

    run_instr(K_MOV, 1'b0, 0);

    // ADD interrupted by reset in its write-back cycle
    fetch_decode(make_cop(K_ADD));
    cyc("add_rd_a", ov(M_SRC, A_PA, T_A, 2'b00, 4'b0), rb(), rb(), ALL);
    cyc("add_rd_b", ov(M_DST, A_PA, T_B, 2'b00, 4'b0), rb(), rb(), ALL);
    do_reset("rst_mid_add_wr");

    run_instr(K_CMP, 1'b0, 0);
    run_instr(K_BEQ, 1'b1, 0);
    run_instr(K_NOP, 1'b0, 0);
    run_instr(K_CMP, 1'b0, 0);
    run_instr(K_BEQ, 1'b0, 0);
    run_instr(K_IN, 1'b0, 3);
    run_instr(K_OUT, 1'b0, 0);

    // IN interrupted by reset while waiting for acknowledge
    fetch_decode(make_cop(K_IN));
    cyc("in_wait", ov(M_DST, A_PA, T_MIO, 2'b00, X_RD), 1'b0, rb(), NO_MIO);
    do_reset("rst_mid_io");

    run_instr(K_PUSH, 1'b0, 0);
    run_instr(K_POP, 1'b0, 0);
    if (TMO > 0) begin
      run_instr(K_OUT, 1'b0, TMO + 3);
      run_instr(K_IN, 1'b0, TMO - 1);
      run_instr(K_NOP, 1'b0, 0);
    end
    run_instr(K_HALT, 1'b0, 0);

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 3)       kind = K_MOV;
      else if (r < 6)  kind = K_ADD;
      else if (r < 8)  kind = K_CMP;
      else if (r < 11) kind = K_BEQ;
      else if (r < 13) kind = K_IN;
      else if (r < 15) kind = K_OUT;
      else if (r < 16) kind = K_PUSH;
      else if (r < 17) kind = K_POP;
      else if (r < 19) kind = K_NOP;
      else             kind = K_HALT;
      run_instr(kind, rb(), int'($urandom_range(0, 6)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
